// File: rtl/mmio_io_unit_if.sv
// Load/store bus between stage_mem and the memory-mapped I/O unit.
// The read data path is combinational in the slave.
interface mmio_io_unit_if;
   logic        io_write;
   logic        io_read;
   logic [31:0] io_addr;
   logic [31:0] io_wdata;
   logic [31:0] io_rdata;

   modport master (
      output io_write, io_read, io_addr, io_wdata,
      input  io_rdata
   );

   modport slave (
      input  io_write, io_read, io_addr, io_wdata,
      output io_rdata
   );
endinterface

// File: rtl/mmio_io_unit.sv
// I/O window behind stage_mem: LED register, 8-digit seven-segment scanner
// and a synchronized, debounced 16-bit switch register.
module mmio_io_unit #(
   parameter logic [23:0] IO_BASE         = 24'hFFFFFC,
   parameter int unsigned SCAN_DIV        = 100000,
   parameter int unsigned DEBOUNCE_CYCLES = 2000000
) (
   input  logic               clk,
   input  logic               rst,
   mmio_io_unit_if.slave      bus,
   input  logic [15:0]        switch,
   output logic [15:0]        led,
   output logic [7:0]         seg_out,
   output logic [7:0]         tub_sel
);

   localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [PW-1:0] SCAN_LAST = PW'(SCAN_DIV - 1);
   // Taking the new value when the pre-increment count is D-2 means the
   // count "reaches" D-1 on that same edge.
   localparam logic [DW-1:0] DB_TAKE   = DW'(DEBOUNCE_CYCLES - 2);

   typedef enum logic [7:0] {
      OFF_LED      = 8'h60,
      OFF_SW       = 8'h70,
      OFF_SEG_DATA = 8'h80,
      OFF_SEG_EN   = 8'h84
   } reg_off_e;

   logic          hit;
   logic [7:0]    off;
   logic          wr_led;
   logic          wr_seg_data;
   logic          wr_seg_en;

   logic [31:0]   seg_data;
   logic [7:0]    seg_en;
   logic [15:0]   sync1;
   logic [15:0]   sync2;
   logic [15:0]   sw_stable;
   logic [DW-1:0] db_cnt;
   logic [PW-1:0] presc;
   logic [2:0]    digit;
   logic [3:0]    nib;

   assign hit         = (bus.io_addr[31:8] == IO_BASE);
   assign off         = bus.io_addr[7:0];
   assign wr_led      = bus.io_write && hit && (off == OFF_LED);
   assign wr_seg_data = bus.io_write && hit && (off == OFF_SEG_DATA);
   assign wr_seg_en   = bus.io_write && hit && (off == OFF_SEG_EN);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         led      <= '0;
         seg_data <= '0;
         seg_en   <= '1;
      end else begin
         if (wr_led)      led      <= bus.io_wdata[15:0];
         if (wr_seg_data) seg_data <= bus.io_wdata;
         if (wr_seg_en)   seg_en   <= bus.io_wdata[7:0];
      end
   end

   always_comb begin
      bus.io_rdata = '0;
      if (bus.io_read && hit) begin
         case (off)
            OFF_LED:      bus.io_rdata = {16'h0000, led};
            OFF_SW:       bus.io_rdata = {16'h0000, sw_stable};
            OFF_SEG_DATA: bus.io_rdata = seg_data;
            OFF_SEG_EN:   bus.io_rdata = {24'h000000, seg_en};
            default:      bus.io_rdata = '0;
         endcase
      end
   end

   // Count only clears on agreement with sw_stable, so bounces of sync while
   // counting do not restart the window.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1     <= '0;
         sync2     <= '0;
         sw_stable <= '0;
         db_cnt    <= '0;
      end else begin
         sync1 <= switch;
         sync2 <= sync1;
         if (sync2 == sw_stable) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_TAKE) begin
            sw_stable <= sync2;
            db_cnt    <= '0;
         end else begin
            db_cnt <= db_cnt + DW'(1);
         end
      end
   end

   function automatic logic [7:0] hex7(input logic [3:0] n);
      hex7 = 8'h00;
      case (n)
         4'h0: hex7 = 8'hFC;
         4'h1: hex7 = 8'h60;
         4'h2: hex7 = 8'hDA;
         4'h3: hex7 = 8'hF2;
         4'h4: hex7 = 8'h66;
         4'h5: hex7 = 8'hB6;
         4'h6: hex7 = 8'hBE;
         4'h7: hex7 = 8'hE0;
         4'h8: hex7 = 8'hFE;
         4'h9: hex7 = 8'hF6;
         4'hA: hex7 = 8'hEE;
         4'hB: hex7 = 8'h3E;
         4'hC: hex7 = 8'h9C;
         4'hD: hex7 = 8'h7A;
         4'hE: hex7 = 8'h9E;
         4'hF: hex7 = 8'h8E;
      endcase
   endfunction

   assign nib = seg_data[{digit, 2'b00} +: 4];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         presc   <= '0;
         digit   <= '0;
         tub_sel <= '0;
         seg_out <= '0;
      end else begin
         if (presc == SCAN_LAST) begin
            presc <= '0;
            digit <= digit + 3'd1;
         end else begin
            presc <= presc + PW'(1);
         end
         tub_sel <= seg_en[digit] ? (8'h01 << digit) : 8'h00;
         seg_out <= seg_en[digit] ? hex7(nib) : 8'h00;
      end
   end

endmodule

// File: tb/tb_mmio_io_unit.sv
// Directed bench for mmio_io_unit with a short scan divider and debounce window.
module tb_mmio_io_unit;
   logic        clk;
   logic        rst;
   logic [15:0] switch;
   logic [15:0] led;
   logic [7:0]  seg_out;
   logic [7:0]  tub_sel;

   int n_total;
   int n_pass;
   int k;

   // Expected segments for 32'h89ABCDEF, digit 0..7 = F,E,D,C,B,A,9,8
   localparam logic [7:0] EXP_SEG [8] = '{8'h8E, 8'h9E, 8'h7A, 8'h9C,
                                          8'h3E, 8'hEE, 8'hF6, 8'hFE};

   mmio_io_unit_if bus ();

   mmio_io_unit #(
      .IO_BASE         (24'hFFFFFC),
      .SCAN_DIV        (4),
      .DEBOUNCE_CYCLES (8)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus.slave),
      .switch  (switch),
      .led     (led),
      .seg_out (seg_out),
      .tub_sel (tub_sel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
      k = k + 1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total = n_total + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
      bus.io_read = 1'b1;
      bus.io_addr = addr;
      #1;
      check(tag, bus.io_rdata, exp);
      bus.io_read = 1'b0;
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data);
      bus.io_write = 1'b1;
      bus.io_addr  = addr;
      bus.io_wdata = data;
      tick();
      bus.io_write = 1'b0;
   endtask

   task automatic do_reset;
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      k = 0;
   endtask

   initial begin
      logic [7:0] one;
      int d;
      n_total = 0;
      n_pass  = 0;
      k       = 0;
      rst          = 1'b0;
      switch       = '0;
      bus.io_write = 1'b0;
      bus.io_read  = 1'b0;
      bus.io_addr  = '0;
      bus.io_wdata = '0;

      // Reset state and first scan drive
      tick();
      tick();
      check("rst_led", 32'(led), 32'h0);
      check("rst_tub", 32'(tub_sel), 32'h0);
      check("rst_seg", 32'(seg_out), 32'h0);
      rst = 1'b1;
      k = 0;
      tick();
      check("first_tub", 32'(tub_sel), 32'h01);
      check("first_seg", 32'(seg_out), 32'hFC);
      rd("rst_seg_en", 32'hFFFFFC84, 32'h000000FF);
      rd("rst_sw", 32'hFFFFFC70, 32'h0);

      // LED register
      wr(32'hFFFFFC60, 32'h0001A5F0);
      check("led_wr", 32'(led), 32'h0000A5F0);
      rd("led_rd", 32'hFFFFFC60, 32'h0000A5F0);
      wr(32'hFFFFFD60, 32'h0000FFFF);
      check("led_oow", 32'(led), 32'h0000A5F0);
      rd("unmapped_64", 32'hFFFFFC64, 32'h0);
      rd("oow_rd", 32'hFFFFFD60, 32'h0);
      bus.io_addr = 32'hFFFFFC60;
      #1;
      check("no_read_strobe", bus.io_rdata, 32'h0);
      wr(32'hFFFFFC70, 32'h0000BEEF);
      rd("sw_ro", 32'hFFFFFC70, 32'h0);

      // Simultaneous read/write returns the pre-write value
      wr(32'hFFFFFC80, 32'h11111111);
      bus.io_read  = 1'b1;
      bus.io_write = 1'b1;
      bus.io_addr  = 32'hFFFFFC80;
      bus.io_wdata = 32'h22222222;
      #1;
      check("rw_old", bus.io_rdata, 32'h11111111);
      tick();
      bus.io_write = 1'b0;
      #1;
      check("rw_new", bus.io_rdata, 32'h22222222);
      bus.io_read = 1'b0;

      // Display scan, all digits enabled
      do_reset();
      wr(32'hFFFFFC80, 32'h89ABCDEF);
      while (k < 37) begin
         tick();
         d = ((k - 1) / 4) % 8;
         one = 8'h01 << d;
         check($sformatf("scan_tub_k%0d", k), 32'(tub_sel), 32'(one));
         check($sformatf("scan_seg_k%0d", k), 32'(seg_out), 32'(EXP_SEG[d]));
         if (k == 36) begin
            bus.io_write = 1'b1;
            bus.io_addr  = 32'hFFFFFC84;
            bus.io_wdata = 32'h0000000F;
         end
      end
      bus.io_write = 1'b0;
      rd("seg_en_rd", 32'hFFFFFC84, 32'h0000000F);
      rd("seg_data_rd", 32'hFFFFFC80, 32'h89ABCDEF);
      while (k < 70) begin
         tick();
         d = ((k - 1) / 4) % 8;
         one = (d < 4) ? (8'h01 << d) : 8'h00;
         check($sformatf("en_tub_k%0d", k), 32'(tub_sel), 32'(one));
         check($sformatf("en_seg_k%0d", k), 32'(seg_out), (d < 4) ? 32'(EXP_SEG[d]) : 32'h0);
      end

      // Debounce: 2 sync edges plus 7 count edges
      switch = '0;
      do_reset();
      switch = 16'h1234;
      repeat (8) begin
         tick();
         rd($sformatf("db_wait_k%0d", k), 32'hFFFFFC70, 32'h0);
      end
      tick();
      rd("db_taken", 32'hFFFFFC70, 32'h00001234);
      switch = 16'hFFFF;
      tick();
      tick();
      tick();
      switch = 16'h1234;
      repeat (12) begin
         tick();
         rd($sformatf("glitch_k%0d", k), 32'hFFFFFC70, 32'h00001234);
      end

      // Reset mid-scan and mid-debounce
      switch = '0;
      do_reset();
      switch = 16'h5555;
      wr(32'hFFFFFC60, 32'h0000BEEF);
      while (k < 21) begin
         tick();
         if (k == 15) switch = 16'h0AAA;
      end
      check("mid_tub_d5", 32'(tub_sel), 32'h20);
      check("mid_seg_d5", 32'(seg_out), 32'hFC);
      rd("mid_sw_old", 32'hFFFFFC70, 32'h00005555);
      check("mid_led", 32'(led), 32'h0000BEEF);
      rst = 1'b0;
      #1;
      check("async_led", 32'(led), 32'h0);
      check("async_tub", 32'(tub_sel), 32'h0);
      check("async_seg", 32'(seg_out), 32'h0);
      rd("async_sw", 32'hFFFFFC70, 32'h0);
      rd("async_seg_en", 32'hFFFFFC84, 32'h000000FF);
      tick();
      check("held_tub", 32'(tub_sel), 32'h0);
      rst = 1'b1;
      k = 0;
      tick();
      check("restart_tub", 32'(tub_sel), 32'h01);
      check("restart_seg", 32'(seg_out), 32'hFC);
      while (k < 9) begin
         tick();
         if (k == 4) check("restart_tub_k4", 32'(tub_sel), 32'h01);
         if (k == 5) check("restart_tub_k5", 32'(tub_sel), 32'h02);
         if (k == 8) rd("redb_wait", 32'hFFFFFC70, 32'h0);
      end
      rd("redb_taken", 32'hFFFFFC70, 32'h00000AAA);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
